// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, reset PC,
// FSM state encodings and the next-pc selector.
package ysyx_23060332_ifu_pkg;

  localparam int InstBus     = 32;
  localparam int InstAddrBus = 32;

  localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_JUMP = 2'd2
  } pc_sel_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060332_pc_reg.sv
// Fetch program counter with its hold / +4 / redirect next-pc mux.
module ysyx_23060332_pc_reg
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  pc_sel_e                sel,
  input  logic [InstAddrBus-1:0] jump_addr,
  output logic [InstAddrBus-1:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_INC:  pc <= pc + 32'd4;
        PC_JUMP: pc <= word_align(jump_addr);
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: issues one imem request at a time, parks the
// returned instruction for the IDU and handles EXU redirects.
module ysyx_23060332_ifu
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   jump_en_i,
  input  logic [InstAddrBus-1:0] jump_addr_i,
  output logic                   imem_req_valid_o,
  output logic [InstAddrBus-1:0] imem_req_addr_o,
  input  logic                   imem_req_ready_i,
  input  logic                   imem_resp_valid_i,
  input  logic [InstBus-1:0]     imem_resp_data_i,
  output logic                   inst_valid_o,
  output logic [InstBus-1:0]     inst_o,
  output logic [InstAddrBus-1:0] inst_addr_o,
  input  logic                   inst_ready_i,
  output logic [63:0]            fetch_cnt_o
);

  logic [2:0]             state;
  logic [2:0]             next_state;
  pc_sel_e                pc_sel;
  logic [InstAddrBus-1:0] pc;
  logic                   latch_inst;
  logic                   handoff;

  ysyx_23060332_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (pc_sel),
    .jump_addr (jump_addr_i),
    .pc        (pc)
  );

  // NOTE: every signal written here gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    pc_sel     = PC_HOLD;
    latch_inst = 1'b0;
    handoff    = 1'b0;
    case (state)
      S_IDLE: next_state = S_REQ;
      S_REQ: begin
        if (jump_en_i) pc_sel = PC_JUMP;
        // An accepted request still owes us a response; DROP swallows it.
        if (imem_req_ready_i) next_state = jump_en_i ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (jump_en_i) begin
          pc_sel     = PC_JUMP;
          next_state = imem_resp_valid_i ? S_REQ : S_DROP;
        end else if (imem_resp_valid_i) begin
          latch_inst = 1'b1;
          next_state = S_HOLD;
        end
      end
      S_DROP: begin
        if (jump_en_i) pc_sel = PC_JUMP;
        if (imem_resp_valid_i) next_state = S_REQ;
      end
      S_HOLD: begin
        if (jump_en_i) begin
          pc_sel     = PC_JUMP;
          next_state = S_REQ;
        end else if (inst_ready_i) begin
          pc_sel     = PC_INC;
          handoff    = 1'b1;
          next_state = S_REQ;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      inst_o      <= '0;
      fetch_cnt_o <= '0;
    end else begin
      state <= next_state;
      if (latch_inst) inst_o <= imem_resp_data_i;
      if (handoff) fetch_cnt_o <= fetch_cnt_o + 64'd1;
    end
  end

  assign imem_req_valid_o = (state == S_REQ);
  assign imem_req_addr_o  = pc;
  // A redirect in HOLD squashes the parked instruction in the same cycle.
  assign inst_valid_o     = (state == S_HOLD) && !jump_en_i;
  assign inst_addr_o      = pc;

endmodule
